// File: rtl/aes_pkg.sv
// Shared AES-128 types, constants and round helper functions.
// Used by aes_round_sequencer and aes_mix_columns.
// Byte 0 of a state sits in bits [127:120], laid out column-major (byte 4*c+r).
package aes_pkg;

  typedef logic [127:0] aes_state_t;
  typedef logic [31:0]  aes_word_t;

  localparam int         AES128_ROUNDS = 10;
  localparam logic [7:0] GF_POLY       = 8'h1B;

  // Sequencer FSM encoding, also exported on the debug state output.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_INIT   = 3'd1,
    ST_SUB    = 3'd2,
    ST_FINISH = 3'd3,
    ST_DONE   = 3'd4
  } aes_fsm_e;

  // Multiply by x in GF(2^8), reducing with x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
  endfunction

  // Row r rotates left by r: out[r][c] = in[r][(c+r)%4].
  function automatic aes_state_t shift_rows(input aes_state_t s);
    aes_state_t o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  // One column times the fixed {02,03,01,01} circulant matrix.
  function automatic aes_word_t mix_word(input aes_word_t w);
    logic [7:0] a0, a1, a2, a3;
    a0 = w[31:24];
    a1 = w[23:16];
    a2 = w[15:8];
    a3 = w[7:0];
    mix_word = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic aes_state_t mix_columns(input aes_state_t s);
    aes_state_t o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      o[127-32*c -: 32] = mix_word(s[127-32*c -: 32]);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_mix_columns.sv
// Combinational MixColumns over a full 128-bit AES state.
// Kept as its own module so the inverse path can sit beside it later.
module aes_mix_columns
  import aes_pkg::*;
(
  input  aes_state_t state_i,
  output aes_state_t state_o
);

  // Pure combinational column mix.
  assign state_o = mix_columns(state_i);

endmodule

// File: rtl/aes_round_sequencer.sv
// AES-128 encryption round sequencer around an external, shared sub_byte unit.
// Optional build macro: AES_SEQ_ABORT_EN adds an abort input that drops the
// block in flight and returns to IDLE without a done pulse.
//
// Handshake: start is sampled only in IDLE; once accepted busy stays high
// until the cycle after the one-cycle done pulse, and any start seen while
// busy is dropped (not queued). dataOut is valid from done until the next done.
module aes_round_sequencer
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS   = AES128_ROUNDS,
  parameter int SBOX_LATENCY = 1  // cycles startTransition is held; must be >= 1
) (
  input  logic         clock50MHz,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] dataIn,
  input  logic [127:0] roundKey,
  output logic [3:0]   roundKeyIndex,
  output logic [127:0] subByteInput,
  output logic         startTransition,
  input  logic [127:0] subByteOutput,
`ifdef AES_SEQ_ABORT_EN
  input  logic         abort,
`endif
  output logic         busy,
  output logic         done,
  output logic [127:0] dataOut,
  output aes_fsm_e     stateDbg
);

  localparam int               WAIT_W     = $clog2(SBOX_LATENCY + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SBOX_LATENCY - 1);
  localparam logic [3:0]        LAST_ROUND = 4'(NUM_ROUNDS);

  aes_fsm_e          state_q, state_d;
  aes_state_t        state_reg_q, state_reg_d;
  logic [3:0]        round_q, round_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  aes_state_t        data_out_q, data_out_d;

  aes_state_t shifted;
  aes_state_t mixed;
  aes_state_t round_result;

  aes_mix_columns u_mix (
    .state_i (shifted),
    .state_o (mixed)
  );

  // ShiftRows, optional MixColumns (skipped in the final round), AddRoundKey.
  always_comb begin
    shifted      = shift_rows(state_reg_q);
    round_result = ((round_q == LAST_ROUND) ? shifted : mixed) ^ roundKey;
  end

  // Next-state logic for the FSM and the datapath registers.
  always_comb begin
    state_d     = state_q;
    state_reg_d = state_reg_q;
    round_d     = round_q;
    wait_d      = wait_q;
    data_out_d  = data_out_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_reg_d = dataIn;
          round_d     = '0;
          state_d     = ST_INIT;
        end
      end
      ST_INIT: begin
        state_reg_d = state_reg_q ^ roundKey;
        round_d     = 4'd1;
        wait_d      = '0;
        state_d     = ST_SUB;
      end
      ST_SUB: begin
        // state_reg_q is not touched until the capture cycle, so sub_byte
        // sees a stable input for the whole time startTransition is high.
        wait_d = wait_q + WAIT_W'(1);
        if (wait_q == WAIT_LAST) begin
          state_reg_d = subByteOutput;
          state_d     = ST_FINISH;
        end
      end
      ST_FINISH: begin
        state_reg_d = round_result;
        if (round_q == LAST_ROUND) begin
          data_out_d = round_result;
          state_d    = ST_DONE;
        end else begin
          round_d = round_q + 4'd1;
          wait_d  = '0;
          state_d = ST_SUB;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
`ifdef AES_SEQ_ABORT_EN
    // Abort only matters once a block is in flight; dataOut keeps the last result.
    if (abort && (state_q != ST_IDLE)) begin
      state_d    = ST_IDLE;
      round_d    = '0;
      wait_d     = '0;
      data_out_d = data_out_q;
    end
`endif
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clock50MHz) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      state_reg_q <= '0;
      round_q     <= '0;
      wait_q      <= '0;
      data_out_q  <= '0;
    end else begin
      state_q     <= state_d;
      state_reg_q <= state_reg_d;
      round_q     <= round_d;
      wait_q      <= wait_d;
      data_out_q  <= data_out_d;
    end
  end

  // Outputs decode straight from registers, so they are glitch-free.
  assign roundKeyIndex   = round_q;
  assign subByteInput    = state_reg_q;
  assign startTransition = (state_q == ST_SUB);
  assign busy            = (state_q != ST_IDLE);
  assign done            = (state_q == ST_DONE);
  assign dataOut         = data_out_q;
  assign stateDbg        = state_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: FIPS-197 C.1 vector on a latency-1 and a
// latency-3 instance, with a behavioural sub_byte and key-store model.
module tb_aes_round_sequencer;
  import aes_pkg::*;

  localparam logic [127:0] PT        = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT        = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] R1_SB_IN  = 128'h00102030405060708090a0b0c0d0e0f0;
  localparam logic [127:0] R1_SB_OUT = 128'h63cab7040953d051cd60e0e7ba70e18c;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference tables ----------------
  logic [127:0] sbox_rows [16] = '{
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  logic [127:0] rk [11] = '{
    128'h000102030405060708090a0b0c0d0e0f, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
    128'hb692cf0b643dbdf1be9bc5006830b3fe, 128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
    128'h47f7f7bc95353e03f96c32bcfd058dfd, 128'h3caaa3e8a99f9deb50f3af57adf622aa,
    128'h5e390f7df7a69296a7553dc10aa31f6b, 128'h14f9701ae35fe28c440adf4d4ea9c026,
    128'h47438735a41c65b9e016baf4aebf7ad2, 128'h549932d1f08557681093ed9cbe2c974e,
    128'h13111d7fe3944a17f307a78b4d2b30c5};

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   b;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      b = s[127-8*i -: 8];
      o[127-8*i -: 8] = sbox_rows[b[7:4]][127-8*int'(b[3:0]) -: 8];
    end
    return o;
  endfunction

  // ---------------- DUT (latency 1) ----------------
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [127:0] dataIn = '0;
  logic [127:0] roundKey, subByteInput, subByteOutput, dataOut;
  logic [3:0]   roundKeyIndex;
  logic         startTransition, busy, done;
  aes_fsm_e     state_dbg;
  int           sb_cnt = 0;

  assign roundKey = (roundKeyIndex <= 4'd10) ? rk[roundKeyIndex] : '0;
  always @(posedge clk) sb_cnt <= startTransition ? sb_cnt + 1 : 0;
  assign subByteOutput = (startTransition && sb_cnt >= 0) ? sub_bytes(subByteInput) : '0;

  aes_round_sequencer #(.NUM_ROUNDS(10), .SBOX_LATENCY(1)) dut (
    .clock50MHz      (clk),
    .reset           (reset),
    .start           (start),
    .dataIn          (dataIn),
    .roundKey        (roundKey),
    .roundKeyIndex   (roundKeyIndex),
    .subByteInput    (subByteInput),
    .startTransition (startTransition),
    .subByteOutput   (subByteOutput),
`ifdef AES_SEQ_ABORT_EN
    .abort           (abort),
`endif
    .busy            (busy),
    .done            (done),
    .dataOut         (dataOut),
    .stateDbg        (state_dbg)
  );

  // ---------------- DUT (latency 3) ----------------
  logic         start3 = 1'b0;
  logic         abort3 = 1'b0;
  logic [127:0] roundKey3, subByteInput3, subByteOutput3, dataOut3;
  logic [3:0]   roundKeyIndex3;
  logic         startTransition3, busy3, done3;
  aes_fsm_e     state_dbg3;
  int           sb_cnt3 = 0;

  assign roundKey3 = (roundKeyIndex3 <= 4'd10) ? rk[roundKeyIndex3] : '0;
  always @(posedge clk) sb_cnt3 <= startTransition3 ? sb_cnt3 + 1 : 0;
  // Output is only meaningful once the input has been held for 3 cycles.
  assign subByteOutput3 = (startTransition3 && sb_cnt3 >= 2) ? sub_bytes(subByteInput3) : '0;

  aes_round_sequencer #(.NUM_ROUNDS(10), .SBOX_LATENCY(3)) dut3 (
    .clock50MHz      (clk),
    .reset           (reset),
    .start           (start3),
    .dataIn          (dataIn),
    .roundKey        (roundKey3),
    .roundKeyIndex   (roundKeyIndex3),
    .subByteInput    (subByteInput3),
    .startTransition (startTransition3),
    .subByteOutput   (subByteOutput3),
`ifdef AES_SEQ_ABORT_EN
    .abort           (abort3),
`endif
    .busy            (busy3),
    .done            (done3),
    .dataOut         (dataOut3),
    .stateDbg        (state_dbg3)
  );

  // ---------------- scoreboard ----------------
  int           total = 0;
  int           bad = 0;
  logic [127:0] exp_q[$];
  int           exp_t_q[$];
  logic [127:0] exp3_q[$];
  int           exp3_t_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor for the latency-1 instance: every done pops one expected block.
  always @(negedge clk) begin
    if (done !== 1'b0) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL done_unexpected: got done=%b with no block pending (edge %0d)", done, cyc);
      end else begin
        check("dataOut", dataOut, exp_q.pop_front());
        check("done_edge", 128'(cyc), 128'(exp_t_q.pop_front()));
      end
    end
  end

  // Monitor for the latency-3 instance.
  always @(negedge clk) begin
    if (done3 !== 1'b0) begin
      if (exp3_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL done3_unexpected: got done=%b with no block pending (edge %0d)", done3, cyc);
      end else begin
        check("dataOut3", dataOut3, exp3_q.pop_front());
        check("done3_edge", 128'(cyc), 128'(exp3_t_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; acc returns the edge number on which start is sampled.
  task automatic issue(input logic [127:0] pt, output int acc);
    start  = 1'b1;
    dataIn = pt;
    acc    = cyc + 1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int acc, acc2, busy_cnt, run, runs, good_runs;

    ticks(3);
    reset = 1'b0;
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_done", 128'(done), 128'd0);
    check("rst_stt", 128'(startTransition), 128'd0);
    check("rst_dataOut", dataOut, 128'd0);
    check("rst_rki", 128'(roundKeyIndex), 128'd0);
    check("rst_sbi", subByteInput, 128'd0);
    check("rst_state", 128'(state_dbg), 128'(ST_IDLE));
    check("rst_busy3", 128'(busy3), 128'd0);

    // Full encryption, latency 1.
    issue(PT, acc);
    exp_q.push_back(CT);
    exp_t_q.push_back(acc + 21);
    check("init_sbi", subByteInput, PT);
    check("init_stt", 128'(startTransition), 128'd0);
    busy_cnt = (busy === 1'b1) ? 1 : 0;
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      if (k <= 21 && busy === 1'b1) busy_cnt++;
      if (k == 1) begin
        check("r1_sub_in", subByteInput, R1_SB_IN);
        check("r1_stt", 128'(startTransition), 128'd1);
        check("r1_rki", 128'(roundKeyIndex), 128'd1);
      end
      if (k == 2) begin
        check("r1_sub_out", subByteInput, R1_SB_OUT);
        check("r1_stt_low", 128'(startTransition), 128'd0);
      end
    end
    check("busy_cycles", 128'(busy_cnt), 128'd22);
    check("idle_busy", 128'(busy), 128'd0);
    check("held_dataOut", dataOut, CT);

    // start while busy is dropped; back-to-back start in the first idle cycle.
    issue(PT, acc);
    exp_q.push_back(CT);
    exp_t_q.push_back(acc + 21);
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      if (k == 4) begin start = 1'b1; dataIn = '0; end
      if (k == 5) begin start = 1'b0; dataIn = PT; end
    end
    check("gap_busy", 128'(busy), 128'd0);
    issue(PT, acc2);
    check("b2b_accept_edge", 128'(acc2), 128'(acc + 23));
    exp_q.push_back(CT);
    exp_t_q.push_back(acc2 + 21);
    ticks(22);
    check("b2b_dataOut", dataOut, CT);

    // Latency-3 instance.
    start3 = 1'b1;
    dataIn = PT;
    acc    = cyc + 1;
    @(negedge clk);
    start3 = 1'b0;
    exp3_q.push_back(CT);
    exp3_t_q.push_back(acc + 41);
    run = 0; runs = 0; good_runs = 0;
    for (int k = 1; k <= 42; k++) begin
      @(negedge clk);
      if (startTransition3 === 1'b1) run++;
      else if (run != 0) begin
        runs++;
        if (run == 3) good_runs++;
        run = 0;
      end
    end
    check("lat3_stt_runs", 128'(runs), 128'd10);
    check("lat3_stt_len3", 128'(good_runs), 128'd10);
    check("lat3_idle", 128'(busy3), 128'd0);

    // Reset in the middle of a block.
    issue(PT, acc);
    ticks(8);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", 128'(busy), 128'd0);
    check("mid_rst_done", 128'(done), 128'd0);
    check("mid_rst_stt", 128'(startTransition), 128'd0);
    check("mid_rst_dataOut", dataOut, 128'd0);
    check("mid_rst_rki", 128'(roundKeyIndex), 128'd0);
    reset = 1'b0;
    ticks(30);

`ifdef AES_SEQ_ABORT_EN
    // Abort: complete one block, abort the next, then run one more.
    issue(PT, acc);
    exp_q.push_back(CT);
    exp_t_q.push_back(acc + 21);
    ticks(22);
    issue(PT, acc);
    ticks(6);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", 128'(busy), 128'd0);
    check("abort_stt", 128'(startTransition), 128'd0);
    check("abort_state", 128'(state_dbg), 128'(ST_IDLE));
    check("abort_dataOut", dataOut, CT);
    ticks(25);
    issue(PT, acc);
    exp_q.push_back(CT);
    exp_t_q.push_back(acc + 21);
    ticks(22);
    check("post_abort_dataOut", dataOut, CT);
`endif

    ticks(2);
    check("pending_blocks", 128'(exp_q.size()), 128'd0);
    check("pending_blocks3", 128'(exp3_q.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Backstop so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
